// File: rtl/mem_dcache_if.sv
// CPU request/response and MEM_core line-transfer signals of the data cache.
// The master side is the environment (LSU + MEM_core). The slave side is the cache.
interface mem_dcache_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned LINE_WIDTH = 128
);
    localparam int unsigned OFF = $clog2(LINE_WIDTH / 8);

    logic                      cpu_req_valid;
    logic                      cpu_req_write;
    logic                      cpu_req_byte;
    logic [ADDR_WIDTH-1:0]     cpu_req_addr;
    logic [31:0]               cpu_req_wdata;
    logic                      cpu_req_ready;
    logic                      cpu_rsp_valid;
    logic [31:0]               cpu_rsp_rdata;
    logic                      mem_read;
    logic                      mem_write;
    logic [ADDR_WIDTH-OFF-1:0] mem_line_addr;
    logic [LINE_WIDTH-1:0]     mem_line_data;
    logic                      mem_rsp_valid;
    logic [LINE_WIDTH-1:0]     mem_rsp_line_data;

    modport master (
        output cpu_req_valid, cpu_req_write, cpu_req_byte, cpu_req_addr, cpu_req_wdata,
        output mem_rsp_valid, mem_rsp_line_data,
        input  cpu_req_ready, cpu_rsp_valid, cpu_rsp_rdata,
        input  mem_read, mem_write, mem_line_addr, mem_line_data
    );

    modport slave (
        input  cpu_req_valid, cpu_req_write, cpu_req_byte, cpu_req_addr, cpu_req_wdata,
        input  mem_rsp_valid, mem_rsp_line_data,
        output cpu_req_ready, cpu_rsp_valid, cpu_rsp_rdata,
        output mem_read, mem_write, mem_line_addr, mem_line_data
    );
endinterface

// File: rtl/mem_dcache.sv
// Direct-mapped, write-back, write-allocate data cache between the LSU and MEM_core.
// Optional hit/miss counters are built when DCACHE_STATS_EN is defined.
module mem_dcache #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned LINE_WIDTH = 128,
    parameter int unsigned NUM_SETS   = 4
) (
    input  logic        clock,
    input  logic        reset,
    mem_dcache_if.slave bus
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0] stat_hits,
    output logic [31:0] stat_misses
`endif
);
    localparam int unsigned OFF = $clog2(LINE_WIDTH / 8);
    localparam int unsigned IDX = $clog2(NUM_SETS);
    localparam int unsigned TAG = ADDR_WIDTH - OFF - IDX;

    typedef enum logic [2:0] {
        StIdle,
        StWb,
        StFillReq,
        StFillWait,
        StRespond
    } state_e;

    state_e                state_q;
    logic [LINE_WIDTH-1:0] data_q [NUM_SETS];
    logic [TAG-1:0]        tag_q  [NUM_SETS];
    logic [NUM_SETS-1:0]   valid_q;
    logic [NUM_SETS-1:0]   dirty_q;

    logic                  req_write_q;
    logic                  req_byte_q;
    logic [ADDR_WIDTH-1:0] req_addr_q;
    logic [31:0]           req_wdata_q;

    // Little-endian lane merge; word stores ignore addr[1:0].
    function automatic logic [LINE_WIDTH-1:0] merge_store(
        input logic [LINE_WIDTH-1:0] line,
        input logic                  is_byte,
        input logic [OFF-1:0]        off,
        input logic [31:0]           wdata
    );
        logic [LINE_WIDTH-1:0] res;
        res = line;
        if (is_byte) begin
            res[{off, 3'b000} +: 8] = wdata[7:0];
        end else begin
            res[{off[OFF-1:2], 5'b00000} +: 32] = wdata;
        end
        return res;
    endfunction

    function automatic logic [31:0] extract_load(
        input logic [LINE_WIDTH-1:0] line,
        input logic                  is_byte,
        input logic [OFF-1:0]        off
    );
        if (is_byte) begin
            return {24'h000000, line[{off, 3'b000} +: 8]};
        end
        return line[{off[OFF-1:2], 5'b00000} +: 32];
    endfunction

    logic [IDX-1:0] cpu_idx;
    logic [TAG-1:0] cpu_tag;
    logic [OFF-1:0] cpu_off;
    logic           accept;
    logic           lookup_hit;

    assign cpu_idx    = bus.cpu_req_addr[OFF+IDX-1:OFF];
    assign cpu_tag    = bus.cpu_req_addr[ADDR_WIDTH-1:OFF+IDX];
    assign cpu_off    = bus.cpu_req_addr[OFF-1:0];
    assign accept     = bus.cpu_req_valid && bus.cpu_req_ready;
    assign lookup_hit = valid_q[cpu_idx] && (tag_q[cpu_idx] == cpu_tag);

    logic [IDX-1:0]        req_idx;
    logic [TAG-1:0]        req_tag;
    logic [OFF-1:0]        req_off;
    logic [LINE_WIDTH-1:0] fill_line;

    assign req_idx = req_addr_q[OFF+IDX-1:OFF];
    assign req_tag = req_addr_q[ADDR_WIDTH-1:OFF+IDX];
    assign req_off = req_addr_q[OFF-1:0];

    // An invalid MEM_core response fills the line with zeros.
    always_comb begin
        fill_line = bus.mem_rsp_valid ? bus.mem_rsp_line_data : '0;
        if (req_write_q) begin
            fill_line = merge_store(fill_line, req_byte_q, req_off, req_wdata_q);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q           <= StIdle;
            valid_q           <= '0;
            dirty_q           <= '0;
            req_write_q       <= 1'b0;
            req_byte_q        <= 1'b0;
            req_addr_q        <= '0;
            req_wdata_q       <= '0;
            bus.cpu_req_ready <= 1'b1;
            bus.cpu_rsp_valid <= 1'b0;
            bus.cpu_rsp_rdata <= '0;
            bus.mem_read      <= 1'b0;
            bus.mem_write     <= 1'b0;
            bus.mem_line_addr <= '0;
            bus.mem_line_data <= '0;
`ifdef DCACHE_STATS_EN
            stat_hits         <= '0;
            stat_misses       <= '0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        req_write_q       <= bus.cpu_req_write;
                        req_byte_q        <= bus.cpu_req_byte;
                        req_addr_q        <= bus.cpu_req_addr;
                        req_wdata_q       <= bus.cpu_req_wdata;
                        bus.cpu_req_ready <= 1'b0;
                        if (lookup_hit) begin
                            if (bus.cpu_req_write) begin
                                data_q[cpu_idx]   <= merge_store(data_q[cpu_idx], bus.cpu_req_byte,
                                                                 cpu_off, bus.cpu_req_wdata);
                                dirty_q[cpu_idx]  <= 1'b1;
                                bus.cpu_rsp_rdata <= '0;
                            end else begin
                                bus.cpu_rsp_rdata <= extract_load(data_q[cpu_idx],
                                                                  bus.cpu_req_byte, cpu_off);
                            end
                            bus.cpu_rsp_valid <= 1'b1;
                            state_q           <= StRespond;
                        end else if (valid_q[cpu_idx] && dirty_q[cpu_idx]) begin
                            bus.mem_write     <= 1'b1;
                            bus.mem_line_addr <= {tag_q[cpu_idx], cpu_idx};
                            bus.mem_line_data <= data_q[cpu_idx];
                            state_q           <= StWb;
                        end else begin
                            bus.mem_read      <= 1'b1;
                            bus.mem_line_addr <= bus.cpu_req_addr[ADDR_WIDTH-1:OFF];
                            state_q           <= StFillReq;
                        end
`ifdef DCACHE_STATS_EN
                        if (lookup_hit) begin
                            stat_hits <= stat_hits + 32'd1;
                        end else begin
                            stat_misses <= stat_misses + 32'd1;
                        end
`endif
                    end
                end
                StWb: begin
                    dirty_q[req_idx]  <= 1'b0;
                    bus.mem_write     <= 1'b0;
                    bus.mem_line_data <= '0;
                    bus.mem_read      <= 1'b1;
                    bus.mem_line_addr <= {req_tag, req_idx};
                    state_q           <= StFillReq;
                end
                StFillReq: begin
                    bus.mem_read      <= 1'b0;
                    bus.mem_line_addr <= '0;
                    state_q           <= StFillWait;
                end
                StFillWait: begin
                    data_q[req_idx]   <= fill_line;
                    tag_q[req_idx]    <= req_tag;
                    valid_q[req_idx]  <= 1'b1;
                    dirty_q[req_idx]  <= req_write_q;
                    bus.cpu_rsp_rdata <= req_write_q ? 32'h0
                                                     : extract_load(fill_line, req_byte_q, req_off);
                    bus.cpu_rsp_valid <= 1'b1;
                    state_q           <= StRespond;
                end
                StRespond: begin
                    bus.cpu_rsp_valid <= 1'b0;
                    bus.cpu_rsp_rdata <= '0;
                    bus.cpu_req_ready <= 1'b1;
                    state_q           <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_dcache.sv
// Self-checking bench for mem_dcache: directed scenarios plus random traffic against an
// architectural byte-memory model and a backing-store model of MEM_core.
module tb_mem_dcache;
    logic clock = 1'b0;
    logic reset = 1'b1;

    always #5 clock = ~clock;

    mem_dcache_if bus ();

`ifdef DCACHE_STATS_EN
    logic [31:0] stat_hits;
    logic [31:0] stat_misses;
`endif

    mem_dcache dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
`ifdef DCACHE_STATS_EN
        ,
        .stat_hits   (stat_hits),
        .stat_misses (stat_misses)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Model: which line each set holds, plus the architectural contents of memory.
    logic [25:0]  m_tag   [4];
    bit           m_valid [4];
    bit           m_dirty [4];
    logic [7:0]   arch    [int unsigned];
    logic [127:0] backing [int unsigned];
    int unsigned  m_hits;
    int unsigned  m_misses;
    logic [31:0]  last_rdata;

    function automatic logic [7:0] arch_byte(input int unsigned a);
        logic [127:0] ln;
        if (arch.exists(a)) return arch[a];
        if (backing.exists(a >> 4)) begin
            ln = backing[a >> 4];
            return ln[(a & 15) * 8 +: 8];
        end
        return 8'h00;
    endfunction

    function automatic logic [127:0] arch_line(input int unsigned la);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[i*8 +: 8] = arch_byte(la * 16 + i);
        return r;
    endfunction

    function automatic logic [31:0] arch_load(input bit is_byte, input int unsigned a);
        int unsigned b;
        if (is_byte) return {24'h0, arch_byte(a)};
        b = a & ~32'd3;
        return {arch_byte(b + 3), arch_byte(b + 2), arch_byte(b + 1), arch_byte(b)};
    endfunction

    task automatic model_store(input bit is_byte, input int unsigned a, input logic [31:0] wd);
        int unsigned b;
        if (is_byte) begin
            arch[a] = wd[7:0];
        end else begin
            b = a & ~32'd3;
            for (int i = 0; i < 4; i++) arch[b + i] = wd[i*8 +: 8];
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_valid[i] = 0;
            m_dirty[i] = 0;
            m_tag[i]   = '0;
        end
        arch.delete();
        m_hits   = 0;
        m_misses = 0;
    endtask

    task automatic do_req(input bit wr, input bit by, input logic [31:0] addr,
                          input logic [31:0] wdata);
        logic [1:0]   ix;
        logic [25:0]  tg;
        bit           hit, dvict, both, pend;
        int           exp_lat, exp_wr, exp_rd, rsp_c, wr_c, rd_c;
        logic [27:0]  exp_wb_addr, got_wb_addr, got_rd_addr, pend_addr;
        logic [127:0] exp_wb_data, got_wb_data;
        logic [31:0]  exp_rdata, got_rdata;
        ix          = addr[5:4];
        tg          = addr[31:6];
        hit         = m_valid[ix] && (m_tag[ix] == tg);
        dvict       = !hit && m_valid[ix] && m_dirty[ix];
        exp_lat     = hit ? 1 : (dvict ? 4 : 3);
        exp_wr      = dvict ? 1 : -1;
        exp_rd      = hit ? -1 : (dvict ? 2 : 1);
        exp_wb_addr = {m_tag[ix], ix};
        exp_wb_data = arch_line(int'(exp_wb_addr));
        exp_rdata   = wr ? 32'h0 : arch_load(by, addr);

        n_checks++;
        if (bus.cpu_req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL ready_idle: got %b want 1", bus.cpu_req_ready);
        end
        bus.cpu_req_valid = 1'b1;
        bus.cpu_req_write = wr;
        bus.cpu_req_byte  = by;
        bus.cpu_req_addr  = addr;
        bus.cpu_req_wdata = wdata;
        @(posedge clock);
        #1;
        bus.cpu_req_valid = 1'b0;
        bus.cpu_req_write = 1'($urandom);
        bus.cpu_req_byte  = 1'($urandom);
        bus.cpu_req_addr  = $urandom;
        bus.cpu_req_wdata = $urandom;

        rsp_c = -1; wr_c = -1; rd_c = -1; both = 0; pend = 0;
        got_wb_addr = '0; got_wb_data = '0; got_rd_addr = '0; got_rdata = '0; pend_addr = '0;
        for (int c = 1; c <= 8; c++) begin
            if (pend && backing.exists(int'(pend_addr))) begin
                bus.mem_rsp_valid     = 1'b1;
                bus.mem_rsp_line_data = backing[int'(pend_addr)];
            end else begin
                bus.mem_rsp_valid     = pend ? 1'b0 : 1'($urandom);
                bus.mem_rsp_line_data = {$urandom, $urandom, $urandom, $urandom};
            end
            pend = 0;
            if (bus.mem_read && bus.mem_write) both = 1;
            if (bus.mem_write && wr_c < 0) begin
                wr_c        = c;
                got_wb_addr = bus.mem_line_addr;
                got_wb_data = bus.mem_line_data;
            end
            if (bus.mem_read) begin
                if (rd_c < 0) begin
                    rd_c        = c;
                    got_rd_addr = bus.mem_line_addr;
                end
                pend      = 1;
                pend_addr = bus.mem_line_addr;
            end
            if (bus.cpu_rsp_valid) begin
                rsp_c     = c;
                got_rdata = bus.cpu_rsp_rdata;
                break;
            end
            @(posedge clock);
            #1;
        end

        n_checks++;
        if (rsp_c != exp_lat) begin
            n_fail++;
            $display("FAIL rsp_latency @%h: got %0d want %0d", addr, rsp_c, exp_lat);
        end
        n_checks++;
        if (got_rdata !== exp_rdata) begin
            n_fail++;
            $display("FAIL rdata @%h: got %h want %h", addr, got_rdata, exp_rdata);
        end
        n_checks++;
        if (wr_c != exp_wr || rd_c != exp_rd || both) begin
            n_fail++;
            $display("FAIL mem_cycles @%h: got wr=%0d rd=%0d both=%0d want wr=%0d rd=%0d both=0",
                     addr, wr_c, rd_c, both, exp_wr, exp_rd);
        end
        if (dvict) begin
            n_checks++;
            if (got_wb_addr !== exp_wb_addr || got_wb_data !== exp_wb_data) begin
                n_fail++;
                $display("FAIL writeback @%h: got %h/%h want %h/%h", addr, got_wb_addr,
                         got_wb_data, exp_wb_addr, exp_wb_data);
            end
        end
        if (!hit) begin
            n_checks++;
            if (got_rd_addr !== {tg, ix}) begin
                n_fail++;
                $display("FAIL fill_addr @%h: got %h want %h", addr, got_rd_addr, {tg, ix});
            end
        end

        @(posedge clock);
        #1;
        n_checks++;
        if (bus.cpu_rsp_valid !== 1'b0 || bus.cpu_req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rsp_pulse @%h: got valid=%b ready=%b want 0/1", addr,
                     bus.cpu_rsp_valid, bus.cpu_req_ready);
        end

        if (hit) begin
            m_hits++;
        end else begin
            m_misses++;
            if (dvict) backing[int'(exp_wb_addr)] = exp_wb_data;
            m_tag[ix]   = tg;
            m_valid[ix] = 1;
            m_dirty[ix] = 0;
        end
        if (wr) begin
            model_store(by, addr, wdata);
            m_dirty[ix] = 1;
        end
        last_rdata = got_rdata;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        n_checks++;
        if (bus.cpu_req_ready !== 1'b1 || bus.cpu_rsp_valid !== 1'b0 ||
            bus.cpu_rsp_rdata !== 32'h0 || bus.mem_read !== 1'b0 || bus.mem_write !== 1'b0 ||
            bus.mem_line_addr !== '0 || bus.mem_line_data !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got rdy=%b v=%b rd=%h mr=%b mw=%b la=%h ld=%h",
                     bus.cpu_req_ready, bus.cpu_rsp_valid, bus.cpu_rsp_rdata, bus.mem_read,
                     bus.mem_write, bus.mem_line_addr, bus.mem_line_data);
        end
`ifdef DCACHE_STATS_EN
        n_checks++;
        if (stat_hits !== 32'h0 || stat_misses !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_stats: got %0d/%0d want 0/0", stat_hits, stat_misses);
        end
`endif
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_directed();
        logic [31:0] want [5];
        want[0] = 32'h00000000;
        want[1] = 32'hDEADBEEF;
        want[2] = 32'hDEADAAEF;
        want[3] = 32'h000000AA;
        want[4] = 32'hDEADAAEF;
        do_req(0, 0, 32'h40, 32'h0);
        n_checks++;
        if (last_rdata !== want[0]) begin
            n_fail++;
            $display("FAIL s1_cold_load: got %h want %h", last_rdata, want[0]);
        end
        do_req(1, 0, 32'h40, 32'hDEADBEEF);
        do_req(0, 0, 32'h40, 32'h0);
        n_checks++;
        if (last_rdata !== want[1]) begin
            n_fail++;
            $display("FAIL s2_hit_load: got %h want %h", last_rdata, want[1]);
        end
        do_req(1, 1, 32'h41, 32'h000000AA);
        do_req(0, 0, 32'h40, 32'h0);
        n_checks++;
        if (last_rdata !== want[2]) begin
            n_fail++;
            $display("FAIL s3_word_after_byte: got %h want %h", last_rdata, want[2]);
        end
        do_req(0, 1, 32'h41, 32'h0);
        n_checks++;
        if (last_rdata !== want[3]) begin
            n_fail++;
            $display("FAIL s3_byte_load: got %h want %h", last_rdata, want[3]);
        end
`ifdef DCACHE_STATS_EN
        n_checks++;
        if (stat_hits !== m_hits || stat_misses !== m_misses) begin
            n_fail++;
            $display("FAIL stats_s1_3: got %0d/%0d want %0d/%0d", stat_hits, stat_misses,
                     m_hits, m_misses);
        end
`endif
        do_req(0, 0, 32'h80, 32'h0);
        do_req(0, 0, 32'h40, 32'h0);
        n_checks++;
        if (last_rdata !== want[4]) begin
            n_fail++;
            $display("FAIL s4_reload: got %h want %h", last_rdata, want[4]);
        end
    endtask

    task automatic test_reset_abort();
        bit saw_rsp;
        saw_rsp = 0;
        bus.cpu_req_valid = 1'b1;
        bus.cpu_req_write = 1'b0;
        bus.cpu_req_byte  = 1'b0;
        bus.cpu_req_addr  = 32'h80;
        @(posedge clock);
        #1;
        bus.cpu_req_valid = 1'b0;
        n_checks++;
        if (bus.mem_read !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_fill_req: got mem_read=%b want 1", bus.mem_read);
        end
        @(posedge clock);
        #1;
        reset                 = 1'b1;
        bus.mem_rsp_valid     = 1'b1;
        bus.mem_rsp_line_data = {4{32'h12345678}};
        if (bus.cpu_rsp_valid) saw_rsp = 1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        if (bus.cpu_rsp_valid) saw_rsp = 1;
        n_checks++;
        if (bus.cpu_req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_ready: got %b want 1", bus.cpu_req_ready);
        end
        @(posedge clock);
        #1;
        if (bus.cpu_rsp_valid) saw_rsp = 1;
        n_checks++;
        if (saw_rsp) begin
            n_fail++;
            $display("FAIL abort_no_rsp: got rsp_valid=1 want 0");
        end
        model_reset();
        do_req(0, 0, 32'h80, 32'h0);
        do_req(0, 0, 32'h40, 32'h0);
    endtask

    task automatic test_random();
        logic [31:0] a;
        for (int i = 0; i < 120; i++) begin
            a = (32'($urandom_range(0, 5)) << 6) | (32'($urandom_range(0, 3)) << 4) |
                32'($urandom_range(0, 15));
            do_req(1'($urandom), 1'($urandom), a, $urandom);
        end
`ifdef DCACHE_STATS_EN
        n_checks++;
        if (stat_hits !== m_hits || stat_misses !== m_misses) begin
            n_fail++;
            $display("FAIL stats_random: got %0d/%0d want %0d/%0d", stat_hits, stat_misses,
                     m_hits, m_misses);
        end
`endif
    endtask

    initial begin
        bus.cpu_req_valid     = 1'b0;
        bus.cpu_req_write     = 1'b0;
        bus.cpu_req_byte      = 1'b0;
        bus.cpu_req_addr      = '0;
        bus.cpu_req_wdata     = '0;
        bus.mem_rsp_valid     = 1'b0;
        bus.mem_rsp_line_data = '0;
        last_rdata            = '0;
        model_reset();
        test_reset();
        test_directed();
        test_reset_abort();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
